// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared instruction-class and load funct3 codes for write-back
package writeback_unit_pkg;

  localparam logic [4:0] RTYPE  = 5'd0;
  localparam logic [4:0] ITYPE  = 5'd1;
  localparam logic [4:0] STYPE  = 5'd2;
  localparam logic [4:0] BTYPE  = 5'd3;
  localparam logic [4:0] LTYPE  = 5'd4;
  localparam logic [4:0] UTYPE  = 5'd5;
  localparam logic [4:0] JTYPE  = 5'd6;
  localparam logic [4:0] JRTYPE = 5'd7;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/writeback_unit_load_align.sv
// rtl/writeback_unit_load_align.sv - load lane select, sign/zero extension and alignment check
module writeback_unit_load_align
  import writeback_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Unsupported funct3 codes are reported the same way as a misaligned access.
  always_comb begin
    o_data       = 32'h0;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU: o_data = {24'h0, w_byte};
      F3_LH: begin
        o_data       = {{16{w_half[15]}}, w_half};
        o_misaligned = i_addr[0];
      end
      F3_LHU: begin
        o_data       = {16'h0, w_half};
        o_misaligned = i_addr[0];
      end
      F3_LW: begin
        o_data       = i_rdata;
        o_misaligned = |i_addr;
      end
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - final pipeline stage: write-back value select, load access, completion
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter logic [2:0] WB_STAGE    = 3'd4,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  stage_i,
  input  logic [4:0]  itype_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] wd_o,
  output logic        wd_q_o,
  output logic [4:0]  wd_rd_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_WRITE, ST_DONE} wb_state_t;

  wb_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_arm;
  logic [4:0]    r_dst;
  logic [2:0]    r_f3;
  logic [31:0]   r_alu;
  logic [31:0]   r_wd;
  logic [4:0]    r_wd_rd;
  logic          r_wdq;
  logic          r_err;

  logic          w_start;
  logic          w_err_nxt;
  logic          w_wr_en;
  logic [31:0]   w_wr_data;
  logic [4:0]    w_wr_rd;
  logic [1:0]    w_al_addr;
  logic [2:0]    w_al_f3;
  logic [31:0]   w_load_data;
  logic          w_misaligned;
  logic          w_unused_opcode;

  assign w_unused_opcode = ^ir_i[6:0];
  assign w_start = (r_state == ST_IDLE) && r_arm && (stage_i == WB_STAGE);

  // The alignment check looks at the live inputs at start; the data path uses the latched copy.
  assign w_al_addr = (r_state == ST_IDLE) ? alu_i[1:0]   : r_alu[1:0];
  assign w_al_f3   = (r_state == ST_IDLE) ? ir_i[14:12]  : r_f3;

  writeback_unit_load_align u_load_align (
    .i_rdata      (mem_rdata_i),
    .i_addr       (w_al_addr),
    .i_funct3     (w_al_f3),
    .o_data       (w_load_data),
    .o_misaligned (w_misaligned)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_data   = 32'h0;
    w_wr_rd     = 5'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_cnt_nxt = '0;
          w_wr_rd   = ir_i[11:7];
          case (itype_i)
            RTYPE, ITYPE: begin
              w_state_nxt = ST_WRITE;
              w_wr_en     = 1'b1;
              w_wr_data   = alu_i;
            end
            UTYPE: begin
              w_state_nxt = ST_WRITE;
              w_wr_en     = 1'b1;
              w_wr_data   = {ir_i[31:12], 12'h0};
            end
            JTYPE, JRTYPE: begin
              w_state_nxt = ST_WRITE;
              w_wr_en     = 1'b1;
              w_wr_data   = pc_i + 32'd4;
            end
            LTYPE: begin
              if (w_misaligned) begin
                w_state_nxt = ST_DONE;
                w_err_nxt   = 1'b1;
              end else begin
                w_state_nxt = ST_MEM;
              end
            end
            default: w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_MEM: begin
        // An ack on the last permitted cycle still wins over the timeout.
        if (mem_ack_i) begin
          w_state_nxt = ST_WRITE;
          w_wr_en     = 1'b1;
          w_wr_data   = w_load_data;
          w_wr_rd     = r_dst;
        end else if (r_cnt == TMO_LAST) begin
          w_state_nxt = ST_DONE;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_WRITE: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_arm   <= 1'b1;
      r_dst   <= 5'd0;
      r_f3    <= 3'd0;
      r_alu   <= 32'h0;
      r_wd    <= 32'h0;
      r_wd_rd <= 5'd0;
      r_wdq   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_wdq   <= w_wr_en && (w_wr_rd != 5'd0);
      if (w_wr_en && (w_wr_rd != 5'd0)) begin
        r_wd    <= w_wr_data;
        r_wd_rd <= w_wr_rd;
      end
      if (w_start) begin
        r_dst <= ir_i[11:7];
        r_f3  <= ir_i[14:12];
        r_alu <= alu_i;
      end
      if (w_start) begin
        r_arm <= 1'b0;
      end else if (stage_i != WB_STAGE) begin
        r_arm <= 1'b1;
      end
    end
  end

  assign mem_req_o  = (r_state == ST_MEM);
  assign mem_addr_o = mem_req_o ? {r_alu[31:2], 2'b00} : 32'h0;
  assign wd_o       = r_wd;
  assign wd_rd_o    = r_wd_rd;
  assign wd_q_o     = r_wdq;
  assign done_o     = (r_state == ST_DONE);
  assign err_o      = r_err;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit with a cycle-level expectation queue
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  stage_i;
  logic [4:0]  itype_i;
  logic [31:0] ir_i, alu_i, pc_i;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        mem_ack_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o, wd_o;
  logic        wd_q_o;
  logic [4:0]  wd_rd_o;
  logic        done_o, err_o;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        wdq;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        done;
    logic        err;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        c_act, c_exp;
  logic [31:0] m_wd = 32'h0;
  logic [4:0]  m_rd = 5'd0;
  int          n_pass = 0;
  int          n_total = 0;
  bit          chk_on = 1'b0;
  int          ack_delay = 99;
  logic [31:0] ack_data = 32'h0;
  int          req_seen = 0;

  always #5 clk = ~clk;

  writeback_unit #(.WB_STAGE(3'd4), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .stage_i(stage_i), .itype_i(itype_i), .ir_i(ir_i),
    .alu_i(alu_i), .pc_i(pc_i), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .wd_o(wd_o), .wd_q_o(wd_q_o),
    .wd_rd_o(wd_rd_o), .done_o(done_o), .err_o(err_o)
  );

  function automatic obs_t blank();
    obs_t o;
    o = '0;
    o.wd = m_wd;
    o.rd = m_rd;
    return o;
  endfunction

  function automatic logic [2:0] idle_stage();
    int v;
    v = $urandom_range(0, 6);
    if (v >= 4) v++;
    return 3'(v);
  endfunction

  function automatic logic [31:0] mk_ir(input logic [19:0] hi, input logic [4:0] rd);
    return {hi, rd, 7'h13};
  endfunction

  function automatic bit load_bad(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * int'(a));
    case (f3)
      3'd0: return int'($signed(sh[7:0]));
      3'd1: return int'($signed(sh[15:0]));
      3'd4: return sh & 32'h0000_00FF;
      3'd5: return sh & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  task automatic chk_obs(input string nm, input obs_t a, input obs_t e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s t=%0t got req=%b addr=%h wdq=%b wd=%h rd=%0d done=%b err=%b required req=%b addr=%h wdq=%b wd=%h rd=%0d done=%b err=%b",
                  nm, $time, a.req, a.addr, a.wdq, a.wd, a.rd, a.done, a.err,
                  e.req, e.addr, e.wdq, e.wd, e.rd, e.done, e.err);
  endtask

  task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s got %h required %h", nm, a, e);
  endtask

  // Memory responder: acks after ack_delay un-acked request cycles, junk data otherwise.
  always @(negedge clk) begin
    if (mem_req_o) begin
      if (req_seen == ack_delay) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = ack_data;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
      end
      req_seen++;
    end else begin
      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
      req_seen    = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      c_act = {mem_req_o, mem_addr_o, wd_q_o, wd_o, wd_rd_o, done_o, err_o};
      if (exp_q.size() > 0) c_exp = exp_q.pop_front();
      else c_exp = blank();
      chk_obs("cycle", c_act, c_exp);
    end
  end

  task automatic run(input logic [4:0] it, input logic [31:0] ir, input logic [31:0] alu,
                     input logic [31:0] pc, input logic [31:0] rdat, input int dly, input bit hold);
    obs_t        r;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] val;
    bit          wr;
    int          n;
    rd = ir[11:7];
    f3 = ir[14:12];
    @(negedge clk);
    stage_i = idle_stage();
    @(negedge clk);
    itype_i = it; ir_i = ir; alu_i = alu; pc_i = pc; stage_i = 3'd4;
    ack_delay = dly; ack_data = rdat;
    @(posedge clk);
    wr = 1'b0;
    val = 32'h0;
    case (it)
      RTYPE, ITYPE:  begin wr = 1'b1; val = alu; end
      UTYPE:         begin wr = 1'b1; val = ir & 32'hFFFF_F000; end
      JTYPE, JRTYPE: begin wr = 1'b1; val = pc + 32'd4; end
      LTYPE: begin
        if (load_bad(f3, alu[1:0])) begin
          r = blank(); r.done = 1'b1; r.err = 1'b1; exp_q.push_back(r);
        end else begin
          n = (dly < TMO) ? dly + 1 : TMO;
          for (int i = 0; i < n; i++) begin
            r = blank(); r.req = 1'b1; r.addr = {alu[31:2], 2'b00}; exp_q.push_back(r);
          end
          if (dly < TMO) begin
            wr = 1'b1;
            val = load_model(f3, alu[1:0], rdat);
          end else begin
            r = blank(); r.done = 1'b1; r.err = 1'b1; exp_q.push_back(r);
          end
        end
      end
      default: ;
    endcase
    if (wr) begin
      r = blank();
      if (rd != 5'd0) begin
        m_wd = val; m_rd = rd;
        r = blank(); r.wdq = 1'b1;
      end
      exp_q.push_back(r);
      r = blank(); r.done = 1'b1; exp_q.push_back(r);
    end else if (it != LTYPE) begin
      r = blank(); r.done = 1'b1; exp_q.push_back(r);
    end
    #1;
    if (!hold) stage_i = idle_stage();
    itype_i = 5'($urandom); ir_i = $urandom; alu_i = $urandom; pc_i = $urandom;
  endtask

  task automatic drain(input string nm);
    int budget;
    budget = 60;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL %s drain timeout: %0d expected cycles left, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [4:0]  it;
    logic [31:0] ir, alu;
    int          dsel, dly;
    reset = 1'b0; stage_i = 3'd0; itype_i = 5'd0; ir_i = 32'h0; alu_i = 32'h0; pc_i = 32'h0;
    repeat (3) @(negedge clk);
    c_act = {mem_req_o, mem_addr_o, wd_q_o, wd_o, wd_rd_o, done_o, err_o};
    chk_obs("reset_state", c_act, '0);
    reset = 1'b1;
    chk_on = 1'b1;

    run(ITYPE, mk_ir(20'h0, 5'd5), 32'h0000_0123, 32'h0, 32'h0, 0, 1'b0); drain("addi");
    chk32("addi_wd", wd_o, 32'h0000_0123);
    chk32("addi_rd", 32'(wd_rd_o), 32'd5);
    run(UTYPE, mk_ir(20'hABCDE, 5'd7), 32'h1111_2222, 32'h0, 32'h0, 0, 1'b0); drain("lui");
    chk32("lui_wd", wd_o, 32'hABCD_E000);
    run(JTYPE, mk_ir(20'h0, 5'd1), 32'h0, 32'hFFFF_FFFC, 32'h0, 0, 1'b0); drain("jal");
    chk32("jal_wrap_wd", wd_o, 32'h0);
    run(LTYPE, mk_ir(20'h0, 5'd3), 32'h0000_1003, 32'h0, 32'h8000_0000, 0, 1'b0); drain("lb");
    chk32("lb_wd", wd_o, 32'hFFFF_FF80);
    run(LTYPE, mk_ir(20'h4, 5'd3), 32'h0000_1003, 32'h0, 32'h8000_0000, 4, 1'b0); drain("lbu");
    chk32("lbu_wd", wd_o, 32'h0000_0080);
    run(LTYPE, mk_ir(20'h1, 5'd4), 32'h0000_1002, 32'h0, 32'h8001_0000, 4, 1'b0); drain("lh5");
    chk32("lh_ack5_wd", wd_o, 32'hFFFF_8001);
    run(LTYPE, mk_ir(20'h1, 5'd4), 32'h0000_1002, 32'h0, 32'h8001_0000, 0, 1'b0); drain("lh1");
    chk32("lh_ack1_wd", wd_o, 32'hFFFF_8001);
    run(LTYPE, mk_ir(20'h2, 5'd6), 32'h0000_1001, 32'h0, 32'h1234_5678, 0, 1'b0); drain("lw_mis");
    chk32("lw_misaligned_wd_held", wd_o, 32'hFFFF_8001);
    run(LTYPE, mk_ir(20'h2, 5'd6), 32'h0000_1000, 32'h0, 32'h1234_5678, 99, 1'b0); drain("lw_tmo");
    chk32("lw_timeout_wd_held", wd_o, 32'hFFFF_8001);
    run(RTYPE, mk_ir(20'h0, 5'd0), 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 1'b0); drain("add_x0");
    chk32("add_x0_wd_held", wd_o, 32'hFFFF_8001);
    run(STYPE, mk_ir(20'h2, 5'd9), 32'h0000_2000, 32'h0, 32'h0, 0, 1'b0); drain("sw");
    run(BTYPE, mk_ir(20'h0, 5'd9), 32'h0000_2000, 32'h0, 32'h0, 0, 1'b0); drain("beq");
    run(ITYPE, mk_ir(20'h0, 5'd9), 32'h0000_0055, 32'h0, 32'h0, 0, 1'b1); drain("hold");
    repeat (4) @(negedge clk);
    chk32("hold_no_restart_wd", wd_o, 32'h0000_0055);

    @(negedge clk); stage_i = idle_stage();
    @(negedge clk);
    chk_on = 1'b0;
    itype_i = LTYPE; ir_i = mk_ir(20'h2, 5'd8); alu_i = 32'h0000_2000; stage_i = 3'd4;
    ack_delay = 99;
    @(posedge clk); #1 stage_i = 3'd0;
    repeat (3) @(negedge clk);
    chk32("req_before_reset", 32'(mem_req_o), 32'd1);
    reset = 1'b0;
    #1;
    c_act = {mem_req_o, mem_addr_o, wd_q_o, wd_o, wd_rd_o, done_o, err_o};
    chk_obs("reset_mid_mem", c_act, '0);
    m_wd = 32'h0; m_rd = 5'd0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    chk_on = 1'b1;
    run(ITYPE, mk_ir(20'h0, 5'd2), 32'h0000_0077, 32'h0, 32'h0, 0, 1'b0); drain("after_reset");
    chk32("after_reset_wd", wd_o, 32'h0000_0077);

    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 9) == 9) it = 5'($urandom_range(8, 31));
      else it = 5'($urandom_range(0, 7));
      ir = $urandom;
      alu = $urandom;
      if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
      dsel = $urandom_range(0, 9);
      if (dsel < 7) dly = $urandom_range(0, 4);
      else if (dsel == 7) dly = TMO - 1;
      else if (dsel == 8) dly = TMO;
      else dly = 99;
      run(it, ir, alu, $urandom, $urandom, dly, 1'b0);
      drain("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
